// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SD card write-data receiver.
package sdcard_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CRC,
        S_ENDB,
        S_NCRC,
        S_STATUS,
        S_BUSY
    } state_e;

    localparam logic [15:0] CRC16_TAPS = 16'h1021;
    localparam logic [2:0]  TOK_ACCEPT = 3'b010;
    localparam logic [2:0]  TOK_CRCERR = 3'b101;

    // DAT0 status frame bit idx (0..4): start 0, token MSB first, end 1.
    function automatic logic status_bit(input logic [2:0] tok, input logic [3:0] idx);
        logic [4:0] frame;
        frame = {1'b0, tok, 1'b1};
        return (idx < 4'd5) ? frame[3'd4 - idx[2:0]] : 1'b1;
    endfunction

endpackage

// File: rtl/sdcrc16_lane.sv
// One-line CRC16 shift register (no final XOR) with synchronous clear and advance.
module sdcrc16_lane
    import sdcard_pkg::*;
#(
    parameter logic [15:0] TAPS = CRC16_TAPS
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clr,
    input  logic        i_adv,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (i_clr) begin
            crc_d = '0;
        end else if (i_adv) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ i_bit) ? TAPS : '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) crc_q <= '0;
        else            crc_q <= crc_d;
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/sdcard_wrdata.sv
// Card-side SD 4-bit write-block receiver: deserialise, CRC16/end-bit check,
// then CRC status token and busy on DAT0.
module sdcard_wrdata
    import sdcard_pkg::*;
#(
    parameter logic [15:0] TAPS        = CRC16_TAPS,
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned BUSY_CYCLES = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pedge,
    input  logic       i_nedge,
    input  logic       i_en,
    input  logic [3:0] i_sd_data,
    output logic [3:0] o_sd_data,
    output logic       o_stb,
    output logic [7:0] o_byte,
    output logic       o_last,
    input  logic       i_busy_hold,
    output logic       o_done,
    output logic       o_crc_err
);

    localparam int unsigned NIBBLES = 2 * BLOCK_BYTES;
    localparam int unsigned NW      = $clog2(NIBBLES + 1);
    localparam int unsigned BW      = $clog2(BUSY_CYCLES + 1);

    state_e          state_q, state_d;
    logic [NW-1:0]   nib_q, nib_d;
    logic [3:0]      bit_q, bit_d;
    logic [BW-1:0]   busy_q, busy_d;
    logic [3:0]      hi_q, hi_d;
    logic [7:0]      byte_q, byte_d;
    logic            stb_q, stb_d, last_q, last_d, done_q, done_d, err_q, err_d;
    logic [3:0]      sd_q, sd_d;
    logic            crc_clr, crc_adv;
    logic [3:0][15:0] crc;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        sdcrc16_lane #(.TAPS(TAPS)) u_lane (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_clr     (crc_clr),
            .i_adv     (crc_adv),
            .i_bit     (i_sd_data[k]),
            .o_crc     (crc[k])
        );
    end

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        byte_d  = byte_q;
        err_d   = err_q;
        sd_d    = sd_q;
        stb_d   = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        crc_clr = 1'b0;
        crc_adv = 1'b0;
        case (state_q)
            S_IDLE: begin
                sd_d = '1;
                if (i_pedge && i_en && i_sd_data == 4'h0) begin
                    state_d = S_DATA;
                    crc_clr = 1'b1;
                    nib_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (i_pedge) begin
                    crc_adv = 1'b1;
                    nib_d   = nib_q + 1'b1;
                    if (!nib_q[0]) begin
                        hi_d = i_sd_data;
                    end else begin
                        byte_d = {hi_q, i_sd_data};
                        stb_d  = 1'b1;
                    end
                    if (nib_q == NW'(NIBBLES - 1)) begin
                        last_d  = 1'b1;
                        bit_d   = '0;
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (i_pedge) begin
                    crc_adv = 1'b1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd15) state_d = S_ENDB;
                end
            end
            S_ENDB: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (i_pedge) begin
                    err_d   = ((crc[0] | crc[1] | crc[2] | crc[3]) != '0) || (i_sd_data != 4'hf);
                    done_d  = 1'b1;
                    bit_d   = '0;
                    state_d = S_NCRC;
                end
            end
            S_NCRC: begin
                if (i_nedge) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd1) begin
                        bit_d   = '0;
                        state_d = S_STATUS;
                    end
                end
            end
            S_STATUS: begin
                if (i_nedge) begin
                    sd_d  = {3'b111, status_bit(err_q ? TOK_CRCERR : TOK_ACCEPT, bit_q)};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd4) begin
                        busy_d  = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // Counter saturates, so release needs only the count and the hold input.
                if (i_nedge) begin
                    if (busy_q == BW'(BUSY_CYCLES) && !i_busy_hold) begin
                        sd_d    = '1;
                        state_d = S_IDLE;
                    end else begin
                        sd_d = 4'he;
                        if (busy_q != BW'(BUSY_CYCLES)) busy_d = busy_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sd_d    = '1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            nib_q   <= '0;
            bit_q   <= '0;
            busy_q  <= '0;
            hi_q    <= '0;
            byte_q  <= '0;
            stb_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sd_q    <= '1;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            byte_q  <= byte_d;
            stb_q   <= stb_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sd_q    <= sd_d;
        end
    end

    assign o_sd_data = sd_q;
    assign o_stb     = stb_q;
    assign o_byte    = byte_q;
    assign o_last    = last_q;
    assign o_done    = done_q;
    assign o_crc_err = err_q;

endmodule
